// File: rtl/adc_capture_if.sv
// Bundles the ADC pins, capture handshake and waveform-RAM write port of adc_capture.
// slave is the capture block's view; master is the controller/ADC/RAM side.
interface adc_capture_if #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 11,
    parameter int DIV_W  = 24
);
    logic              start;
    logic [DIV_W-1:0]  divider;
    logic [DATA_W-1:0] trig_level;
    logic [DATA_W-1:0] adc_data;
    logic              adc_clock;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;

    modport master (
        output start, divider, trig_level, adc_data,
        input  adc_clock, wr_en, wr_addr, wr_data, busy, done
    );

    modport slave (
        input  start, divider, trig_level, adc_data,
        output adc_clock, wr_en, wr_addr, wr_data, busy, done
    );
endinterface

// File: rtl/adc_capture.sv
// Divided ADC sample clock plus one fixed-length record capture into the waveform RAM.
// Define ADC_TRIGGER_EN to arm on a rising-edge level crossing before recording.
module adc_capture #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2000,
    parameter int DIV_W  = 24
) (
    input logic          clk_400M,
    input logic          rst_n,
    adc_capture_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_CAPT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [1:0]        state, state_nx;
    logic [DIV_W-1:0]  div_q, div_nx;
    logic [DIV_W-1:0]  cnt, cnt_nx;
    logic [DIV_W:0]    half;
    logic              adc_clk_q, adc_clk_nx;
    logic [DATA_W-1:0] smp;
    logic              smp_vld;
    logic [ADDR_W-1:0] idx;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              accept, sample_pt, trigger, store, issue, busy_nx;

    assign accept    = (state == S_IDLE) && bus.start;
    assign sample_pt = ((state == S_ARM) || (state == S_CAPT)) && (cnt == div_q);

`ifdef ADC_TRIGGER_EN
    logic have_prev;

    // smp still holds the previous sample while the new one sits on adc_data
    assign trigger = sample_pt && (state == S_ARM) && have_prev &&
                     (smp < bus.trig_level) && (bus.adc_data >= bus.trig_level);

    always_ff @(posedge clk_400M or negedge rst_n) begin
        if (!rst_n)
            have_prev <= 1'b0;
        else if (accept)
            have_prev <= 1'b0;
        else if (sample_pt)
            have_prev <= 1'b1;
    end
`else
    logic unused_trig;
    assign unused_trig = ^bus.trig_level;
    assign trigger     = 1'b0;
`endif

    assign store = sample_pt && ((state == S_CAPT) || trigger);
    assign issue = smp_vld && (state == S_CAPT);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
`ifdef ADC_TRIGGER_EN
                if (bus.start) state_nx = S_ARM;
`else
                if (bus.start) state_nx = S_CAPT;
`endif
            end
            S_ARM:  if (trigger) state_nx = S_CAPT;
            S_CAPT: if (wr_en_q && (wr_addr_q == LAST_ADDR)) state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        div_nx = div_q;
        if (accept)
            div_nx = (bus.divider == '0) ? DIV_W'(1) : bus.divider;
        busy_nx = (state_nx == S_ARM) || (state_nx == S_CAPT);
        cnt_nx  = '0;
        if (busy_nx && !accept && (cnt != div_q))
            cnt_nx = cnt + DIV_W'(1);
        // computed from next-state values so adc_clock lines up with cnt
        half       = ({1'b0, div_nx} + (DIV_W+1)'(1)) >> 1;
        adc_clk_nx = busy_nx && ({1'b0, cnt_nx} >= half);
    end

    always_ff @(posedge clk_400M or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            div_q     <= DIV_W'(1);
            cnt       <= '0;
            adc_clk_q <= 1'b0;
            smp       <= '0;
            smp_vld   <= 1'b0;
            idx       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state     <= state_nx;
            div_q     <= div_nx;
            cnt       <= cnt_nx;
            adc_clk_q <= adc_clk_nx;
            smp_vld   <= store;
            wr_en_q   <= issue;
            if (sample_pt)
                smp <= bus.adc_data;
            if (issue) begin
                wr_addr_q <= idx;
                wr_data_q <= smp;
            end
            if (accept || (state == S_DONE))
                idx <= '0;
            else if (issue)
                idx <= idx + ADDR_W'(1);
        end
    end

    assign bus.adc_clock = adc_clk_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.busy      = (state == S_ARM) || (state == S_CAPT);
    assign bus.done      = (state == S_DONE);
endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture: record timing, divider edge cases, ignored restarts,
// back-to-back records, asynchronous abort and (with ADC_TRIGGER_EN) level triggering.
module tb_adc_capture;
    localparam int DEPTH = 2000;
    localparam int RB    = 'h0100;

    logic clk_400M = 1'b0;
    logic rst_n    = 1'b0;
    int   vectors  = 0;
    int   errors   = 0;

    adc_capture_if bus ();

    adc_capture dut (
        .clk_400M (clk_400M),
        .rst_n    (rst_n),
        .bus      (bus.slave)
    );

    always #5 clk_400M = ~clk_400M;

    function automatic logic [13:0] ramp(input int base, input int step, input int n);
        return 14'(base + step * n);
    endfunction

    task automatic tick();
        @(posedge clk_400M);
        #1;
    endtask

    task automatic test_reset();
        bus.start      = 1'b0;
        bus.divider    = '0;
        bus.trig_level = '0;
        bus.adc_data   = '0;
        rst_n = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({bus.busy, bus.done, bus.wr_en, bus.adc_clock, bus.wr_addr, bus.wr_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%0b done=%0b wr_en=%0b adc_clock=%0b addr=%0h data=%0h, all required 0",
                     bus.busy, bus.done, bus.wr_en, bus.adc_clock, bus.wr_addr, bus.wr_data);
        end
        rst_n = 1'b1;
        repeat (2) tick();
        vectors++;
        if ({bus.busy, bus.done, bus.wr_en, bus.adc_clock} !== 4'b0) begin
            errors++;
            $display("FAIL reset_idle: busy/done/wr_en/adc_clock=%b required 0000",
                     {bus.busy, bus.done, bus.wr_en, bus.adc_clock});
        end
    endtask

    // One full record; returns in the DONE cycle. restart_at: write index at which a
    // stray start with divider=7 is pulsed (-1 for none).
    task automatic test_record(input int div, input int restart_at);
        int   p;
        int   last_j;
        int   k;
        logic exp_wr, exp_busy, exp_done, exp_clk;
        p      = (div == 0) ? 2 : div + 1;
        last_j = p + 1 + (DEPTH - 1) * p;
        k      = 0;
        bus.divider  = 24'(div);
        bus.adc_data = ramp(RB, 1, 0);
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int j = 0; j <= last_j + 1; j++) begin
            exp_wr   = (j >= p + 1) && (((j - p - 1) % p) == 0) && (j <= last_j);
            exp_busy = (j <= last_j);
            exp_done = (j == last_j + 1);
            exp_clk  = exp_busy && ((j % p) >= (p / 2));
            vectors += 4;
            if (bus.wr_en !== exp_wr) begin
                errors++;
                $display("FAIL rec%0d_wr_en j=%0d: got %b required %b", div, j, bus.wr_en, exp_wr);
            end
            if (bus.busy !== exp_busy) begin
                errors++;
                $display("FAIL rec%0d_busy j=%0d: got %b required %b", div, j, bus.busy, exp_busy);
            end
            if (bus.done !== exp_done) begin
                errors++;
                $display("FAIL rec%0d_done j=%0d: got %b required %b", div, j, bus.done, exp_done);
            end
            if (bus.adc_clock !== exp_clk) begin
                errors++;
                $display("FAIL rec%0d_adc_clock j=%0d: got %b required %b", div, j, bus.adc_clock, exp_clk);
            end
            bus.start = 1'b0;
            if (exp_wr) begin
                vectors += 2;
                if (bus.wr_addr !== 11'(k)) begin
                    errors++;
                    $display("FAIL rec%0d_addr write %0d: got %0h required %0h", div, k, bus.wr_addr, 11'(k));
                end
                if (bus.wr_data !== ramp(RB, 1, k)) begin
                    errors++;
                    $display("FAIL rec%0d_data write %0d: got %0h required %0h", div, k, bus.wr_data, ramp(RB, 1, k));
                end
                if (k == restart_at) begin
                    bus.start   = 1'b1;
                    bus.divider = 24'd7;
                end
                k++;
            end
            bus.adc_data = ramp(RB, 1, j / p);
            if (j <= last_j) tick();
        end
    endtask

    task automatic test_back_to_back();
        // start held through the DONE cycle (ignored) into the following IDLE cycle
        bus.divider = 24'd7;
        bus.start   = 1'b1;
        tick();
        vectors++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_start_in_done: busy/done=%b required 00", {bus.busy, bus.done});
        end
        test_record(1, -1);
    endtask

    task automatic test_async_reset();
        bus.divider  = 24'd2;
        bus.adc_data = ramp(RB, 1, 0);
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int j = 1; j <= 4; j++) tick();
        vectors++;
        if ({bus.busy, bus.wr_en, bus.adc_clock, bus.wr_addr} !== {3'b111, 11'h0}) begin
            errors++;
            $display("FAIL abort_precondition: busy/wr_en/adc_clock=%b addr=%0h required 111 addr 0",
                     {bus.busy, bus.wr_en, bus.adc_clock}, bus.wr_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.busy, bus.wr_en, bus.adc_clock, bus.done} !== 4'b0) begin
            errors++;
            $display("FAIL abort_async: busy/wr_en/adc_clock/done=%b required 0000",
                     {bus.busy, bus.wr_en, bus.adc_clock, bus.done});
        end
        #2 rst_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick();
            vectors++;
            if ({bus.busy, bus.wr_en, bus.done, bus.adc_clock} !== 4'b0) begin
                errors++;
                $display("FAIL abort_quiet cycle %0d: busy/wr_en/done/adc_clock=%b required 0000",
                         j, {bus.busy, bus.wr_en, bus.done, bus.adc_clock});
            end
        end
    endtask

`ifdef ADC_TRIGGER_EN
    task automatic test_trigger();
        logic exp_wr;
        bus.trig_level = 14'h2000;
        bus.divider    = 24'd3;
        bus.adc_data   = ramp('h1FF0, 8, 0);
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int j = 0; j <= 20; j++) begin
            exp_wr = (j == 13) || (j == 17);
            vectors += 2;
            if (bus.wr_en !== exp_wr) begin
                errors++;
                $display("FAIL trig_wr_en j=%0d: got %b required %b", j, bus.wr_en, exp_wr);
            end
            if (bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL trig_busy j=%0d: got %b required 1", j, bus.busy);
            end
            if (j == 13 || j == 17) begin
                vectors++;
                if ({bus.wr_addr, bus.wr_data} !== {11'(j == 17), ramp('h1FF0, 8, (j == 17) ? 3 : 2)}) begin
                    errors++;
                    $display("FAIL trig_write j=%0d: addr=%0h data=%0h required addr=%0h data=%0h", j,
                             bus.wr_addr, bus.wr_data, 11'(j == 17), ramp('h1FF0, 8, (j == 17) ? 3 : 2));
                end
            end
            bus.adc_data = ramp('h1FF0, 8, j / 4);
            tick();
        end
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        bus.adc_data = 14'h3000;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int j = 0; j < 60; j++) begin
            vectors++;
            if ({bus.wr_en, bus.busy} !== 2'b01) begin
                errors++;
                $display("FAIL trig_flat j=%0d: wr_en/busy=%b required 01", j, {bus.wr_en, bus.busy});
            end
            tick();
        end
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
    endtask
`else
    task automatic test_trig_ignored();
        logic exp_wr;
        bus.trig_level = 14'h2000;
        bus.divider    = 24'd3;
        bus.adc_data   = ramp('h1FF0, 8, 0);
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int j = 0; j <= 9; j++) begin
            exp_wr = (j == 5) || (j == 9);
            vectors++;
            if (bus.wr_en !== exp_wr) begin
                errors++;
                $display("FAIL notrig_wr_en j=%0d: got %b required %b", j, bus.wr_en, exp_wr);
            end
            if (j == 5) begin
                vectors++;
                if ({bus.wr_addr, bus.wr_data} !== {11'h0, 14'h1FF0}) begin
                    errors++;
                    $display("FAIL notrig_first_write: addr=%0h data=%0h required addr=0 data=1ff0",
                             bus.wr_addr, bus.wr_data);
                end
            end
            bus.adc_data = ramp('h1FF0, 8, j / 4);
            tick();
        end
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_record(3, -1);
        tick();
        test_record(0, -1);
        tick();
        test_record(3, 100);
        test_back_to_back();
        tick();
        test_async_reset();
`ifdef ADC_TRIGGER_EN
        test_trigger();
`else
        test_trig_ignored();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
